// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: computes segment*16+offset fetch addresses, runs
// req/ack bus reads in 8- or 16-bit mode and queues bytes for the decoder.
module prefetch_unit #(
  parameter int          DEPTH     = 6,
  parameter int          BUS_BYTES = 1,
  parameter int          ADDR_W    = 20,
  parameter logic [15:0] RESET_IP  = 16'h0000,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            cs,
  input  logic                   flush,
  input  logic [15:0]            flush_ip,
  output logic                   bus_req,
  output logic [ADDR_W-1:0]      bus_addr,
  input  logic                   bus_ack,
  input  logic [8*BUS_BYTES-1:0] bus_rdata,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            exec_ip,
  output logic [15:0]            fetch_ip,
  output logic [CW-1:0]          count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            odd_start;
  logic [CW-1:0]   need, free_slots;
  logic            launch, take, pop;
  logic [15:0]     rdata_w;
  logic [7:0]      first_byte, second_byte;
  logic [ADDR_W-1:0] seg_base, addr_launch;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // An odd offset on a 16-bit bus only yields the upper byte of the word.
  assign odd_start  = (BUS_BYTES == 2) && fetch_ip[0];
  assign need       = ((BUS_BYTES == 1) || odd_start) ? CW'(1) : CW'(2);
  assign free_slots = CW'(DEPTH) - count;
  assign take       = (state == REQ) && bus_ack;
  assign pop        = out_valid && out_ready;
  assign bus_req    = (state == REQ);

  assign rdata_w     = 16'(bus_rdata);
  assign first_byte  = odd_start ? rdata_w[15:8] : rdata_w[7:0];
  assign second_byte = rdata_w[15:8];

  assign seg_base = ADDR_W'({cs, 4'b0000});

  always_comb begin
    addr_launch = seg_base + ADDR_W'(fetch_ip);
    if (BUS_BYTES == 2) addr_launch[0] = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (free_slots >= need) begin
          launch    = 1'b1;
          state_nxt = REQ;
        end
        REQ:  if (bus_ack) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_addr <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_ip <= RESET_IP;
      exec_ip  <= RESET_IP;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_ip <= flush_ip;
      exec_ip  <= flush_ip;
    end else begin
      if (launch) bus_addr <= addr_launch;
      if (take) begin
        wr_ptr   <= (need == CW'(2)) ? ptr_inc(ptr_inc(wr_ptr)) : ptr_inc(wr_ptr);
        fetch_ip <= fetch_ip + 16'(need);
      end
      if (pop) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        exec_ip <= exec_ip + 16'd1;
      end
      count <= count + (take ? need : CW'(0)) - CW'(pop);
    end
  end

  // Storage needs no reset: out_byte is gated by out_valid.
  always_ff @(posedge clk) begin
    if (take && !flush) begin
      mem[wr_ptr] <= first_byte;
      if (need == CW'(2)) mem[ptr_inc(wr_ptr)] <= second_byte;
    end
  end

  assign out_valid = (count != '0);
  assign out_byte  = out_valid ? mem[rd_ptr] : 8'h00;

endmodule
